// File: rtl/div_reconstruct8_pkg.sv
// Shared definitions for the div_reconstruct8 dividend reconstructor.
// Holds the FSM state encoding and the default quotient/divisor widths.
package div_reconstruct8_pkg;

  localparam int unsigned QW_DEFAULT = 8;
  localparam int unsigned DW_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_reconstruct8_shift_add_step.sv
// One iteration of the radix-2 shift-add multiplier.
// Ports:
//   acc      - current accumulator value
//   b        - divisor (multiplicand)
//   qbit     - current quotient bit; the shifted divisor is added only when set
//   shamt    - iteration index, i.e. the weight of qbit
//   acc_next - accumulator after this iteration
module shift_add_step #(
  parameter int unsigned QW = 8,
  parameter int unsigned DW = 7,
  parameter int unsigned CW = 4
) (
  input  logic [QW+DW-1:0] acc,
  input  logic [DW-1:0]    b,
  input  logic             qbit,
  input  logic [CW-1:0]    shamt,
  output logic [QW+DW-1:0] acc_next
);

  localparam int unsigned AW = QW + DW;

  logic [AW-1:0] b_ext;

  assign b_ext    = AW'(b);
  // Widest term is b << (QW-1); the final sum never exceeds (2^QW-1)*2^DW, so AW bits suffice.
  assign acc_next = qbit ? (acc + (b_ext << shamt)) : acc;

endmodule

// File: rtl/div_reconstruct8.sv
// Sequential dividend reconstructor: a = quo*b + rem.
// Accepts a request in IDLE, spends QW iterations adding b<<i for each set quotient
// bit (LSB first) onto an accumulator seeded with rem, then presents the result in DONE.
// err flags a quo/b/rem triple that no legal divide could produce (b==0 or rem>=b).
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   in_valid/in_ready    - request handshake, carrying quo, b, rem
//   out_valid/out_ready  - result handshake, carrying a, err
module div_reconstruct8
  import div_reconstruct8_pkg::*;
#(
  parameter int unsigned QW = QW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [QW-1:0]   quo,
  input  logic [DW-1:0]   b,
  input  logic [QW-1:0]   rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW+DW-1:0] a,
  output logic            err
);

  localparam int unsigned AW = QW + DW;
  // Counter must reach QW, which marks "all iterations done".
  localparam int unsigned CW = $clog2(QW + 1);

  state_e        state_q, state_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_pend_q, err_pend_d;
  logic [AW-1:0] a_q, a_d;
  logic          err_q, err_d;
  logic [AW-1:0] step_acc;

  shift_add_step #(
    .QW (QW),
    .DW (DW),
    .CW (CW)
  ) u_step (
    .acc      (acc_q),
    .b        (b_q),
    .qbit     (quo_q[0]),
    .shamt    (cnt_q),
    .acc_next (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    a_d        = a_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          quo_d      = quo;
          b_d        = b;
          acc_d      = AW'(rem);
          cnt_d      = '0;
          err_pend_d = (b == '0) || (AW'(rem) >= AW'(b));
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(QW)) begin
          // Result registers only move here, so a/err stay stable outside DONE entry.
          a_d     = acc_q;
          err_d   = err_pend_q;
          state_d = DONE;
        end else begin
          acc_d = step_acc;
          // Shift the quotient so the current bit is always at index 0.
          quo_d = quo_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      a_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      a_q        <= a_d;
      err_q      <= err_d;
    end
  end

  assign a   = a_q;
  assign err = err_q;

endmodule

// File: tb/tb_div_reconstruct8.sv
// Self-checking bench for div_reconstruct8: directed vectors plus random requests
// checked against an arithmetic reference (a = quo*b + rem, err = b==0 || rem>=b).
module tb_div_reconstruct8;

  localparam int LAT = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  quo = '0;
  logic [6:0]  b = '0;
  logic [7:0]  rem = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] a;
  logic        err;

  int checks = 0;
  int errors = 0;

  div_reconstruct8 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quo       (quo),
    .b         (b),
    .rem       (rem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ref_a(input int q, input int d, input int r);
    return 15'(q * d + r);
  endfunction

  function automatic logic ref_err(input int d, input int r);
    return (d == 0) || (r >= d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one request, returns just after the accepting edge.
  task automatic issue(input logic [7:0] q, input logic [6:0] d, input logic [7:0] r);
    int k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    quo = q; b = d; rem = r; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b0;
    quo = 8'd3; b = 7'd5; rem = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a !== 15'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b a=%0d err=%b, want 1 0 0 0",
               in_ready, out_valid, a, err);
    end
    reset = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_accept: in_ready=%b, want 0 after first edge out of reset", in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat != LAT || a !== 15'd16 || err !== 1'b0) begin
      errors++;
      $display("FAIL first_result: lat=%0d a=%0d err=%b, want %0d 16 0", lat, a, err, LAT);
    end
    step();
  endtask

  task automatic test_directed();
    int lat;
    int vec[6][3] = '{'{12, 4, 2}, '{255, 127, 126}, '{255, 127, 255},
                      '{5, 0, 3}, '{13, 3, 3}, '{0, 9, 5}};
    out_ready = 1'b1;
    foreach (vec[i]) begin
      issue(8'(vec[i][0]), 7'(vec[i][1]), 8'(vec[i][2]));
      wait_valid(lat);
      checks++;
      if (lat != LAT || a !== ref_a(vec[i][0], vec[i][1], vec[i][2]) ||
          err !== ref_err(vec[i][1], vec[i][2])) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d a=%0d err=%b, want %0d %0d %b", i, lat, a, err,
                 LAT, ref_a(vec[i][0], vec[i][1], vec[i][2]), ref_err(vec[i][1], vec[i][2]));
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL one_cycle_%0d: out_valid=%b in_ready=%b, want 0 1", i, out_valid,
                 in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    out_ready = 1'b0;
    issue(8'd100, 7'd7, 8'd3);
    wait_valid(lat);
    checks++;
    if (lat != LAT || a !== 15'd703 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: lat=%0d a=%0d err=%b, want %0d 703 0", lat, a, err, LAT);
    end
    quo = 8'd1; b = 7'd1; rem = 8'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (a !== 15'd703 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: a=%0d in_ready=%b out_valid=%b, want 703 0 1", i, a,
                 in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || a !== 15'd703) begin
      errors++;
      $display("FAIL bp_no_queue: valid_cycles=%0d a=%0d, want 0 703", seen, a);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    out_ready = 1'b1;
    issue(8'd200, 7'd100, 8'd50);
    step(); step(); step();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a !== 15'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b a=%0d err=%b, want 1 0 0 0",
               in_ready, out_valid, a, err);
    end
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: valid_cycles=%0d, want 0", seen);
    end
    issue(8'd5, 7'd20, 8'd18);
    wait_valid(lat);
    checks++;
    if (lat != LAT || a !== 15'd118 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: lat=%0d a=%0d err=%b, want %0d 118 0", lat, a, err, LAT);
    end
    step();
  endtask

  task automatic test_random();
    int q, d, r, lat, w;
    logic [14:0] prev_a, exp_a;
    logic exp_err;
    prev_a = a;
    for (int n = 0; n < 1000; n++) begin
      q = int'($urandom_range(0, 255));
      d = int'($urandom_range(1, 127));
      r = int'($urandom_range(0, d - 1));
      exp_a = ref_a(q, d, r);
      exp_err = ref_err(d, r);
      out_ready = 1'($urandom_range(0, 1));
      issue(8'(q), 7'(d), 8'(r));
      lat = 0;
      while (!out_valid && lat < 40) begin
        checks++;
        if (a !== prev_a) begin
          errors++;
          $display("FAIL rnd_stable_run_%0d: a=%0d, want %0d", n, a, prev_a);
        end
        out_ready = 1'($urandom_range(0, 1));
        step();
        lat++;
      end
      checks++;
      if (lat != LAT || a !== exp_a || err !== exp_err) begin
        errors++;
        $display("FAIL rnd_%0d: q=%0d b=%0d r=%0d lat=%0d a=%0d err=%b, want %0d %0d %b", n,
                 q, d, r, lat, a, err, LAT, exp_a, exp_err);
      end
      w = 0;
      while (!out_ready && w < 50) begin
        step();
        checks++;
        if (a !== exp_a || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL rnd_hold_%0d: a=%0d out_valid=%b, want %0d 1", n, a, out_valid,
                   exp_a);
        end
        out_ready = 1'($urandom_range(0, 1));
        w++;
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_pop_%0d: out_valid=%b in_ready=%b, want 0 1", n, out_valid,
                 in_ready);
      end
      prev_a = exp_a;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_reconstruct8.md
DIV_RECONSTRUCT8 -- requirements
Module: div_reconstruct8

Interface
REQ-001 Parameter QW, default 8: quotient and remainder width.
REQ-002 Parameter DW, default 7: divisor width.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1: request holds a valid quo/b/rem triple.
REQ-006 in_ready  output  1: block can accept a request.
REQ-007 quo  input  QW: quotient to reconstruct from.
REQ-008 b  input  DW: divisor.
REQ-009 rem  input  QW: remainder.
REQ-010 out_valid  output  1: result fields valid.
REQ-011 out_ready  input  1: consumer accepts the result.
REQ-012 a  output  QW+DW: reconstructed dividend, quo*b+rem.
REQ-013 err  output  1: request inconsistent with a legal divide result.

Function
REQ-014 The block shall compute a = quo*b + rem with a sequential radix-2 shift-add multiplier, one quotient bit per cycle, LSB first.
REQ-015 FSM states shall be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid the block shall latch quo, b and rem, load the accumulator with zero-extended rem, clear the bit counter, and go to RUN.
REQ-017 RUN: each cycle, if the current quotient bit is 1, the block shall add b shifted left by the counter value into the accumulator; the counter shall increment.
REQ-018 RUN shall last exactly QW cycles; after the last iteration the FSM shall go to DONE.
REQ-019 Latency: out_valid shall rise QW+1 rising edges after the accepting edge (9 for the default).
REQ-020 DONE: out_valid=1, and a and err shall hold stable; the FSM shall return to IDLE on the edge where out_ready=1.
REQ-021 in_ready shall be 0 in RUN and DONE; in_valid in those states shall be ignored, with no queuing.
REQ-022 No overflow shall be possible: the maximum result (2^QW-1)*2^DW fits in QW+DW bits, and the accumulator shall be exactly QW+DW bits wide.
REQ-023 err shall be set at acceptance if b==0 or rem>=b, using zero-extended compare; the product shall still be computed and reported.
REQ-024 If quo==0, the block shall still take the full QW RUN cycles, and the result shall be a=rem.
REQ-025 If out_ready=1 when DONE is entered, the result shall be presented for exactly one cycle; a new request shall then be acceptable on the next IDLE cycle.
REQ-026 a and err shall change only on the transition into DONE.

Reset
REQ-027 On reset=0 the FSM shall enter IDLE immediately; out_valid, a, err and the counter shall go to 0, and in_ready shall be 1.
REQ-028 Reset asserted mid-RUN or in DONE shall abort the operation; no result shall be emitted after release.
REQ-029 The first acceptance after reset release shall occur no earlier than the first rising edge with reset=1.

Structure
REQ-030 A shared package shall hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default QW/DW values.
REQ-031 One sub-module, shift_add_step, shall implement the combinational conditional shifted add for one iteration; the FSM and registers shall remain in the top module.

Verification
REQ-032 quo=12, b=4, rem=2 -> a=50, err=0, out_valid 9 cycles after acceptance.
REQ-033 quo=255, b=127, rem=126 -> a=32511, err=0; and quo=255, b=127, rem=255 -> a=32640, err=1 (no truncation).
REQ-034 quo=5, b=0, rem=3 -> a=3, err=1; and quo=13, b=3, rem=3 -> a=42, err=1.
REQ-035 Back-pressure: out_ready held 0 for 5 cycles in DONE -> a stable, in_ready=0, and a second in_valid is ignored; a then pops on the out_ready edge.
REQ-036 reset pulsed low in the 4th RUN cycle -> outputs 0 and IDLE at once, no out_valid; a following request quo=5, b=20, rem=18 -> a=118.
REQ-037 Self-check: random quo, b≠0 and rem<b, compared against a reference model over 1000 requests with random out_ready.
